// File: rtl/f2h_sdram_pkg.sv
// Shared definitions for the f2h_sdram read-port arbiter.
// Contents: arbiter state encoding and the default f2h_sdram bus widths.
package f2h_sdram_pkg;

    localparam int F2HSDRAM_DW     = 256;
    localparam int F2HSDRAM_ADDRW  = 27;
    localparam int F2HSDRAM_BURSTW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/f2h_sdram_read_arbiter_rr_arbiter2.sv
// Two-way round-robin pick with a port-0 urgent override.
// Ports:
//   req_i     per-port request
//   urgent_i  port 0 wins whenever it requests
//   rr_last_i port granted most recently (0 or 1)
//   win_o     one-hot winner, 0 when nobody requests
module rr_arbiter2
    import f2h_sdram_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       urgent_i,
    input  logic       rr_last_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = 2'b00;
        // On a tie the port that was not served last goes first.
        if (req_i[0] && (urgent_i || !req_i[1] || rr_last_i)) begin
            win_o = 2'b01;
        end else if (req_i[1]) begin
            win_o = 2'b10;
        end
    end

endmodule

// File: rtl/f2h_sdram_read_arbiter.sv
// Shares the single f2h_sdram bursting read port between the video fetch
// (port 0) and a secondary reader (port 1). The grant is held from command
// issue until the last beat of the burst, so beats never interleave.
// Ports:
//   clk_i, rst_n_i                      clock, async active-low reset
//   s_read_i/s_address_i/s_burstcount_i per-port read requests
//   s_waitrequest_o, s_readdatavalid_o  per-port handshake / beat valid
//   s_readdata_o                        return data broadcast to both ports
//   urgent0_i                           port 0 priority override (IDLE only)
//   m_*                                 f2h_sdram master side
//   grant_o, busy_o, err_o              status; err_o pulses on zero burst,
//                                       stray beat or inter-beat timeout
//
// state | meaning
// IDLE  | arbitrate; a zero-length winner is consumed and flagged
// CMD   | m_read_o asserted, waiting for !m_waitrequest_i
// DATA  | forwarding beats to the owner, watching for a stalled burst
module f2h_sdram_read_arbiter
    import f2h_sdram_pkg::*;
#(
    parameter int DATA_W      = F2HSDRAM_DW,
    parameter int ADDR_W      = F2HSDRAM_ADDRW,
    parameter int BURST_W     = F2HSDRAM_BURSTW,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [1:0]           s_read_i,
    input  logic [2*ADDR_W-1:0]  s_address_i,
    input  logic [2*BURST_W-1:0] s_burstcount_i,
    output logic [1:0]           s_waitrequest_o,
    output logic [DATA_W-1:0]    s_readdata_o,
    output logic [1:0]           s_readdatavalid_o,
    input  logic                 urgent0_i,
    output logic [ADDR_W-1:0]    m_address_o,
    output logic [BURST_W-1:0]   m_burstcount_o,
    output logic                 m_read_o,
    input  logic                 m_waitrequest_i,
    input  logic [DATA_W-1:0]    m_readdata_i,
    input  logic                 m_readdatavalid_i,
    output logic [1:0]           grant_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC);

    arb_state_e           state_q, state_d;
    logic                 rr_last_q, rr_last_d;
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           consume_q, consume_d;
    logic [ADDR_W-1:0]    m_address_q, m_address_d;
    logic [BURST_W-1:0]   m_burstcount_q, m_burstcount_d;
    logic                 m_read_q, m_read_d;
    logic [BURST_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 err_q, err_d;

    logic [1:0]           arb_req;
    logic [1:0]           win;
    logic [ADDR_W-1:0]    win_addr;
    logic [BURST_W-1:0]   win_bc;

    // While a zero-length request is being consumed its requester still
    // holds s_read; suppress arbitration so it is not picked twice.
    assign arb_req = (consume_q != 2'b00) ? 2'b00 : s_read_i;

    rr_arbiter2 u_rr (
        .req_i     (arb_req),
        .urgent_i  (urgent0_i),
        .rr_last_i (rr_last_q),
        .win_o     (win)
    );

    assign win_addr = win[1] ? s_address_i[ADDR_W +: ADDR_W]
                             : s_address_i[0 +: ADDR_W];
    assign win_bc   = win[1] ? s_burstcount_i[BURST_W +: BURST_W]
                             : s_burstcount_i[0 +: BURST_W];

    always_comb begin
        state_d        = state_q;
        rr_last_d      = rr_last_q;
        grant_d        = grant_q;
        consume_d      = 2'b00;
        m_address_d    = m_address_q;
        m_burstcount_d = m_burstcount_q;
        m_read_d       = m_read_q;
        beat_cnt_d     = beat_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        err_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (m_readdatavalid_i) begin
                    err_d = 1'b1;
                end
                if (win != 2'b00) begin
                    if (win_bc == '0) begin
                        consume_d = win;
                        err_d     = 1'b1;
                    end else begin
                        grant_d        = win;
                        m_address_d    = win_addr;
                        m_burstcount_d = win_bc;
                        m_read_d       = 1'b1;
                        state_d        = CMD;
                    end
                end
            end
            CMD: begin
                if (m_readdatavalid_i) begin
                    err_d = 1'b1;
                end
                if (!m_waitrequest_i) begin
                    m_read_d   = 1'b0;
                    beat_cnt_d = m_burstcount_q;
                    tmo_cnt_d  = TMO_LOAD;
                    rr_last_d  = grant_q[1];
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (m_readdatavalid_i) begin
                    tmo_cnt_d  = TMO_LOAD;
                    beat_cnt_d = beat_cnt_q - 1'b1;
                    if (beat_cnt_q == BURST_W'(1)) begin
                        grant_d = 2'b00;
                        state_d = IDLE;
                    end
                end else if (tmo_cnt_q == TMO_W'(1)) begin
                    err_d   = 1'b1;
                    grant_d = 2'b00;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            default: begin
                grant_d  = 2'b00;
                m_read_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= IDLE;
            rr_last_q      <= 1'b1;
            grant_q        <= 2'b00;
            consume_q      <= 2'b00;
            m_address_q    <= '0;
            m_burstcount_q <= '0;
            m_read_q       <= 1'b0;
            beat_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_last_q      <= rr_last_d;
            grant_q        <= grant_d;
            consume_q      <= consume_d;
            m_address_q    <= m_address_d;
            m_burstcount_q <= m_burstcount_d;
            m_read_q       <= m_read_d;
            beat_cnt_q     <= beat_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            err_q          <= err_d;
        end
    end

    always_comb begin
        s_waitrequest_o = 2'b11;
        if (state_q == CMD) begin
            s_waitrequest_o = ~(grant_q & {2{~m_waitrequest_i}});
        end
        s_waitrequest_o = s_waitrequest_o & ~consume_q;
    end

    assign s_readdatavalid_o = (state_q == DATA && m_readdatavalid_i) ? grant_q : 2'b00;
    assign s_readdata_o      = (state_q == DATA) ? m_readdata_i : '0;
    assign m_address_o       = m_address_q;
    assign m_burstcount_o    = m_burstcount_q;
    assign m_read_o          = m_read_q;
    assign grant_o           = grant_q;
    assign busy_o            = (state_q != IDLE);
    assign err_o             = err_q;

endmodule
